// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO, any DEPTH >= 2, with level flags and optional FWFT read.
// Define SYNC_FIFO_ERR_EN to add sticky overflow/underflow flags and err_clr.
module sync_fifo_flags #(
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = 8,
    parameter int AF_LEVEL   = 12,
    parameter int AE_LEVEL   = 2,
    parameter int FWFT       = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         w_en,
    input  logic [DATA_WIDTH-1:0]        data_in,
    input  logic                         r_en,
    output logic [DATA_WIDTH-1:0]        data_out,
    output logic                         full,
    output logic                         empty,
    output logic                         almost_full,
    output logic                         almost_empty,
`ifdef SYNC_FIFO_ERR_EN
    input  logic                         err_clr,
    output logic                         overflow,
    output logic                         underflow,
`endif
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_CNT = CW'(AE_LEVEL);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         wr_ptr_nxt;
    logic [PW-1:0]         rd_ptr_nxt;
    logic [CW-1:0]         count_nxt;
    logic                  wr_ok;
    logic                  rd_ok;

    // A write into a full FIFO is legal when a pop frees a slot same cycle.
    always_comb begin
        rd_ok      = r_en && !empty;
        wr_ok      = w_en && (!full || rd_ok);
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        count_nxt  = count;
        if (wr_ok) wr_ptr_nxt = (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
        if (rd_ok) rd_ptr_nxt = (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
        case ({wr_ok, rd_ok})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            empty        <= 1'b1;
            full         <= 1'b0;
            almost_empty <= 1'b1;
            almost_full  <= 1'b0;
        end else begin
            wr_ptr       <= wr_ptr_nxt;
            rd_ptr       <= rd_ptr_nxt;
            count        <= count_nxt;
            empty        <= (count_nxt == '0);
            full         <= (count_nxt == FULL_CNT);
            almost_empty <= (count_nxt <= AE_CNT);
            almost_full  <= (count_nxt >= AF_CNT);
        end
    end

    always_ff @(posedge clk) begin
        if (rst && wr_ok) mem[wr_ptr] <= data_in;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is shown directly; zero while nothing is stored.
            assign data_out = empty ? '0 : mem[rd_ptr];
        end else begin : g_std
            logic [DATA_WIDTH-1:0] dout_q;
            always_ff @(posedge clk) begin
                if (!rst)       dout_q <= '0;
                else if (rd_ok) dout_q <= mem[rd_ptr];
            end
            assign data_out = dout_q;
        end
    endgenerate

`ifdef SYNC_FIFO_ERR_EN
    logic ovf_set;
    logic udf_set;

    assign ovf_set = w_en && !wr_ok;
    assign udf_set = r_en && empty;

    // A new error in the clearing cycle must not be lost.
    always_ff @(posedge clk) begin
        if (!rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (ovf_set)      overflow <= 1'b1;
            else if (err_clr) overflow <= 1'b0;
            if (udf_set)      underflow <= 1'b1;
            else if (err_clr) underflow <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed bench for sync_fifo_flags: DEPTH 16 std, DEPTH 12 std, DEPTH 16 FWFT.
// Sticky error checks compile in when SYNC_FIFO_ERR_EN is defined.
module tb_sync_fifo_flags;

    logic       clk;
    logic       rst;
    int         n_assert;
    int         n_fail;

    logic       a_w, a_r;
    logic [7:0] a_d, a_dout;
    logic       a_full, a_empty, a_af, a_ae;
    logic [4:0] a_count;

    logic       b_w, b_r;
    logic [7:0] b_d, b_dout;
    logic       b_full, b_empty, b_af, b_ae;
    logic [3:0] b_count;

    logic       c_w, c_r;
    logic [7:0] c_d, c_dout;
    logic       c_full, c_empty, c_af, c_ae;
    logic [4:0] c_count;

`ifdef SYNC_FIFO_ERR_EN
    logic a_clr, a_ovf, a_udf;
    logic b_clr, b_ovf, b_udf;
    logic c_clr, c_ovf, c_udf;
`endif

    sync_fifo_flags #(
        .DEPTH(16), .DATA_WIDTH(8), .AF_LEVEL(12), .AE_LEVEL(2), .FWFT(0)
    ) u_a (
        .clk(clk), .rst(rst), .w_en(a_w), .data_in(a_d), .r_en(a_r),
        .data_out(a_dout), .full(a_full), .empty(a_empty),
        .almost_full(a_af), .almost_empty(a_ae),
`ifdef SYNC_FIFO_ERR_EN
        .err_clr(a_clr), .overflow(a_ovf), .underflow(a_udf),
`endif
        .count(a_count)
    );

    sync_fifo_flags #(
        .DEPTH(12), .DATA_WIDTH(8), .AF_LEVEL(10), .AE_LEVEL(2), .FWFT(0)
    ) u_b (
        .clk(clk), .rst(rst), .w_en(b_w), .data_in(b_d), .r_en(b_r),
        .data_out(b_dout), .full(b_full), .empty(b_empty),
        .almost_full(b_af), .almost_empty(b_ae),
`ifdef SYNC_FIFO_ERR_EN
        .err_clr(b_clr), .overflow(b_ovf), .underflow(b_udf),
`endif
        .count(b_count)
    );

    sync_fifo_flags #(
        .DEPTH(16), .DATA_WIDTH(8), .AF_LEVEL(12), .AE_LEVEL(2), .FWFT(1)
    ) u_c (
        .clk(clk), .rst(rst), .w_en(c_w), .data_in(c_d), .r_en(c_r),
        .data_out(c_dout), .full(c_full), .empty(c_empty),
        .almost_full(c_af), .almost_empty(c_ae),
`ifdef SYNC_FIFO_ERR_EN
        .err_clr(c_clr), .overflow(c_ovf), .underflow(c_udf),
`endif
        .count(c_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst = 1'b0;
        a_w = 0; a_r = 0; a_d = '0;
        b_w = 0; b_r = 0; b_d = '0;
        c_w = 0; c_r = 0; c_d = '0;
`ifdef SYNC_FIFO_ERR_EN
        a_clr = 0; b_clr = 0; c_clr = 0;
`endif
        step();
        chk("rst_count", a_count, 0);
        chk("rst_empty", a_empty, 1);
        chk("rst_full", a_full, 0);
        chk("rst_ae", a_ae, 1);
        chk("rst_af", a_af, 0);
        chk("rst_dout", a_dout, 0);
        rst = 1'b1;

        // fill to full, flags track count
        a_w = 1;
        for (int i = 1; i <= 16; i++) begin
            a_d = 8'(i);
            step();
            chk("fill_count", a_count, i);
            chk("fill_af", a_af, (i >= 12) ? 1 : 0);
            chk("fill_ae", a_ae, (i <= 2) ? 1 : 0);
            chk("fill_full", a_full, (i == 16) ? 1 : 0);
        end
        a_d = 8'd17;
        step();
        chk("ovf_count", a_count, 16);
        chk("ovf_full", a_full, 1);
`ifdef SYNC_FIFO_ERR_EN
        chk("ovf_flag", a_ovf, 1);
`endif
        a_w = 0;

        // drain with one-cycle read latency
        a_r = 1;
        for (int i = 1; i <= 16; i++) begin
            step();
            chk("drain_dout", a_dout, i);
            chk("drain_count", a_count, 16 - i);
        end
        chk("drain_empty", a_empty, 1);
        chk("drain_ae", a_ae, 1);
        step();
        chk("udf_dout", a_dout, 16);
        chk("udf_empty", a_empty, 1);
        chk("udf_count", a_count, 0);
`ifdef SYNC_FIFO_ERR_EN
        chk("udf_flag", a_udf, 1);
        a_r = 0;
        a_clr = 1;
        step();
        a_clr = 0;
        chk("clr_ovf", a_ovf, 0);
        chk("clr_udf", a_udf, 0);
`endif
        a_r = 0;

        // simultaneous read/write while full, then while empty
        a_w = 1;
        for (int i = 1; i <= 16; i++) begin
            a_d = 8'(100 + i);
            step();
        end
        chk("rw_full_pre", a_full, 1);
        a_r = 1;
        for (int j = 0; j < 5; j++) begin
            a_d = 8'(200 + j);
            step();
            chk("rw_full_count", a_count, 16);
            chk("rw_full_dout", a_dout, 101 + j);
        end
        a_w = 0;
        for (int k = 0; k < 16; k++) begin
            step();
            chk("rw_drain_dout", a_dout, (k < 11) ? 106 + k : 200 + k - 11);
        end
        chk("rw_drain_empty", a_empty, 1);
        a_w = 1;
        a_d = 8'h55;
        step();
        a_w = 0;
        chk("rw_empty_count", a_count, 1);
        chk("rw_empty_empty", a_empty, 0);
        chk("rw_empty_dout", a_dout, 204);
        step();
        a_r = 0;
        chk("rw_empty_pop", a_dout, 8'h55);

        // DEPTH 12 wrap: 12 writes, 18 paired, 12 reads
        b_w = 1;
        for (int i = 0; i < 12; i++) begin
            b_d = 8'(i);
            step();
            chk("b_fill_af", b_af, (i + 1 >= 10) ? 1 : 0);
        end
        chk("b_full", b_full, 1);
        chk("b_count_full", b_count, 12);
        b_r = 1;
        for (int j = 0; j < 18; j++) begin
            b_d = 8'(12 + j);
            step();
            chk("b_rw_count", b_count, 12);
            chk("b_rw_dout", b_dout, j);
        end
        b_w = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            chk("b_drain_dout", b_dout, 18 + k);
            chk("b_drain_count", b_count, 11 - k);
        end
        b_r = 0;
        chk("b_empty", b_empty, 1);

        // FWFT
        chk("c_rst_empty", c_empty, 1);
        chk("c_rst_dout", c_dout, 0);
        c_w = 1;
        c_d = 8'hA5;
        step();
        c_w = 0;
        chk("c_fwft_dout", c_dout, 8'hA5);
        chk("c_fwft_empty", c_empty, 0);
        c_r = 1;
        step();
        c_r = 0;
        chk("c_pop_empty", c_empty, 1);
        c_w = 1;
        c_d = 8'h11;
        step();
        c_d = 8'h22;
        step();
        c_w = 0;
        chk("c_head0", c_dout, 8'h11);
        c_r = 1;
        step();
        chk("c_head1", c_dout, 8'h22);
        step();
        c_r = 0;
        chk("c_pop2_empty", c_empty, 1);

        // reset mid-stream
        a_w = 1;
        for (int i = 0; i < 8; i++) begin
            a_d = 8'(i + 1);
            step();
        end
        a_w = 0;
        chk("mid_count", a_count, 8);
        chk("mid_ae", a_ae, 0);
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("mid_rst_count", a_count, 0);
        chk("mid_rst_empty", a_empty, 1);
        chk("mid_rst_ae", a_ae, 1);
        chk("mid_rst_dout", a_dout, 0);
        a_w = 1;
        a_d = 8'h3C;
        step();
        a_w = 0;
        chk("post_rst_count", a_count, 1);
        a_r = 1;
        step();
        a_r = 0;
        chk("post_rst_dout", a_dout, 8'h3C);
        chk("post_rst_empty", a_empty, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
